rgmii_tx_framer: RTL and testbench
==================================

// Module: rgmii_tx_framer
// PURPOSE
// Ethernet TX framing stage feeding the RGMII output DDR registers (oddr instances, one per data/ctl pin).
// Accepts a byte stream (valid/ready/last), emits preamble+SFD, payload, zero pad, CRC32 FCS and IFG.
// Each cycle presents one byte split into rising/falling nibbles (d1/d2) plus ctl pair for the DDR stage.
// PARAMETERS
// MIN_FRAME  60  minimum bytes before FCS (DA..payload); shorter frames zero-padded; 0 disables pad
// IFG_BYTES  12  idle byte-times after FCS or abort before next preamble (>=1)
// PORTS
// clk            in   1  byte clock (125 MHz for 1G); all logic on posedge
// rst            in   1  synchronous, active-high reset
// s_tdata        in   8  payload byte (DA first)
// s_tvalid       in   1  s_tdata valid
// s_tlast        in   1  last payload byte of frame
// s_tready       out  1  byte accepted when s_tvalid&s_tready
// txd_d1         out  4  nibble for rising edge = byte[3:0] -> oddr d1
// txd_d2         out  4  nibble for falling edge = byte[7:4] -> oddr d2
// txctl_d1       out  1  TX_EN -> oddr d1 of ctl pin
// txctl_d2       out  1  TX_EN xor TX_ER -> oddr d2 of ctl pin
// frame_done     out  1  1-cycle pulse with last FCS byte
// underrun       out  1  1-cycle pulse when a frame is aborted
// BEHAVIOUR
// - Reset: all outputs 0 (txd=0, ctl=0, s_tready=0, pulses=0); state IDLE; CRC=0xFFFFFFFF; counters 0.
// - All outputs registered; byte driven in cycle N+1 for state/data decided in cycle N.
// - States: IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG.
// - IDLE: ctl=00, txd=0. s_tvalid=1 -> PRE; first 0x55 on outputs next cycle. s_tready=0.
// - PRE: 7 bytes 0x55 (txd_d1=5,txd_d2=5), ctl=11 -> SFD. SFD: 1 byte 0xD5 (d1=5,d2=D), ctl=11 -> DATA.
// - DATA: s_tready=1; each accepted byte driven with ctl=11, fed to CRC, byte count++ (11-bit, saturates 2047).
//   accepted with s_tlast: -> PAD if count<MIN_FRAME else FCS.
//   s_tvalid=0 in DATA (underrun): drive byte 0x00 with ctl=10 (TX_ER) for 1 cycle, pulse underrun,
//   -> DROP if no tlast seen. No FCS sent.
// - DROP: ctl=00, s_tready=1, discard bytes until s_tlast accepted -> IFG.
// - PAD: drive 0x00 with ctl=11, through CRC, until count==MIN_FRAME -> FCS.
// - FCS: 4 bytes = ~CRC, LSB byte first, ctl=11; frame_done with 4th byte -> IFG.
// - CRC32: reflected poly 0xEDB88320, init 0xFFFFFFFF, byte-wise, covers DA..pad; reinit in SFD.
// - IFG: IFG_BYTES cycles ctl=00, txd=0, s_tready=0 -> IDLE. Back-to-back: next PRE starts IFG_BYTES+1
//   cycles after last FCS byte (one IDLE cycle).
// - s_tready is 1 only in DATA and DROP; s_tdata ignored elsewhere.
// - 1-byte frame (tlast on first DATA byte): valid; padded per MIN_FRAME.
// - rst mid-frame: next cycle outputs all 0, IDLE; no FCS, no IFG, no pulses; upstream must re-send.
// - Simultaneous tlast and underrun impossible (tlast requires valid); underrun only on valid=0.
// TESTING
// - MIN_FRAME=0, payload "123456789" (31..39) -> 7x55, D5, 9 bytes, FCS 26 39 F4 CB, frame_done on CB.
// - MIN_FRAME=60, 14-byte payload -> 46 pad bytes 0x00, total 8+60+4 ctl=11 cycles, then 12 cycles ctl=00.
// - Two frames back-to-back, s_tvalid held 1 -> exactly 13 idle cycles between last FCS and next 0x55.
// - s_tvalid dropped after 5th DATA byte -> one cycle ctl_d1=1,ctl_d2=0; underrun pulse; bytes to tlast drained with tready=1; no FCS.
// - rst asserted at DATA byte 20 -> next cycle ctl=00, txd=0, s_tready=0; new frame then starts with 7x55 normally.
// - Nibble order: payload byte 0xA7 -> txd_d1=0x7, txd_d2=0xA, txctl_d1=txctl_d2=1.

Source files
------------

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: Ethernet TX framer (preamble/SFD, payload, pad, FCS, IFG) feeding RGMII DDR output registers
// Ports: clk/rst (sync, active-high); s_tdata/s_tvalid/s_tlast/s_tready byte stream in;
//        txd_d1/txd_d2 low/high nibble and txctl_d1 (TX_EN) / txctl_d2 (TX_EN^TX_ER) to the oddr stage;
//        frame_done pulses with the last FCS byte, underrun pulses when a frame is aborted.
module rgmii_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       txctl_d1,
    output logic       txctl_d2,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG} state_t;
    localparam logic [10:0] MIN = MIN_FRAME[10:0];
    localparam logic [10:0] GAP = IFG_BYTES[10:0];
    state_t      state, state_n;
    logic [10:0] cnt, cnt_n, cnt_inc;
    logic [31:0] crc, crc_n, fcs;
    logic [7:0]  byte_n;
    logic        en_n, er_n, done_n, urun_n;
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction
    // cnt is shared: preamble index, byte count (saturating), FCS index, IFG timer
    assign cnt_inc = (cnt == 11'h7ff) ? cnt : cnt + 11'd1;
    assign fcs     = ~crc;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        crc_n   = crc;
        byte_n  = 8'h00;
        en_n    = 1'b0;
        er_n    = 1'b0;
        done_n  = 1'b0;
        urun_n  = 1'b0;
        case (state)
            IDLE: if (s_tvalid) begin
                // the first preamble byte is launched from IDLE so it appears on the very next cycle
                state_n = PRE;
                cnt_n   = 11'd1;
                byte_n  = 8'h55;
                en_n    = 1'b1;
            end
            PRE: begin
                byte_n  = 8'h55;
                en_n    = 1'b1;
                cnt_n   = cnt_inc;
                state_n = (cnt == 11'd6) ? SFD : PRE;
            end
            SFD: begin
                byte_n  = 8'hD5;
                en_n    = 1'b1;
                crc_n   = '1;
                cnt_n   = '0;
                state_n = DATA;
            end
            DATA: if (s_tvalid) begin
                byte_n = s_tdata;
                en_n   = 1'b1;
                crc_n  = crc_byte(crc, s_tdata);
                cnt_n  = cnt_inc;
                if (s_tlast) begin
                    state_n = (cnt_inc < MIN) ? PAD : FCS;
                    cnt_n   = (cnt_inc < MIN) ? cnt_inc : '0;
                end
            end else begin
                en_n    = 1'b1;
                er_n    = 1'b1;
                urun_n  = 1'b1;
                state_n = DROP;
            end
            PAD: begin
                en_n    = 1'b1;
                crc_n   = crc_byte(crc, 8'h00);
                state_n = (cnt_inc >= MIN) ? FCS : PAD;
                cnt_n   = (cnt_inc >= MIN) ? '0 : cnt_inc;
            end
            FCS: begin
                byte_n  = fcs[{cnt[1:0], 3'b000} +: 8];
                en_n    = 1'b1;
                done_n  = cnt[1:0] == 2'd3;
                state_n = done_n ? IFG : FCS;
                cnt_n   = done_n ? '0 : cnt_inc;
            end
            DROP: if (s_tvalid && s_tlast) begin
                state_n = IFG;
                cnt_n   = '0;
            end
            // one byte-time beyond IFG_BYTES stands in for the IDLE cycle, so back-to-back
            // frames see IFG_BYTES+1 idle bytes between the last FCS byte and the next preamble
            IFG: begin
                cnt_n   = cnt_inc;
                state_n = (cnt == GAP) ? IDLE : IFG;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            crc        <= '1;
            s_tready   <= 1'b0;
            txd_d1     <= '0;
            txd_d2     <= '0;
            txctl_d1   <= 1'b0;
            txctl_d2   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            crc        <= crc_n;
            s_tready   <= (state_n == DATA) || (state_n == DROP);
            txd_d1     <= byte_n[3:0];
            txd_d2     <= byte_n[7:4];
            txctl_d1   <= en_n;
            txctl_d2   <= en_n ^ er_n;
            frame_done <= done_n;
            underrun   <= urun_n;
        end
    end
endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb_rgmii_tx_framer: randomized self-checking bench for rgmii_tx_framer (MIN_FRAME=0 and MIN_FRAME=60 instances)
module tb_rgmii_tx_framer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata [2];
    logic       tvalid [2], tlast [2], tready [2];
    logic [3:0] d1 [2], d2 [2];
    logic       c1 [2], c2 [2], done [2], urun [2];
    int         n_chk = 0, n_fail = 0, cyc = 0, idle_bad = 0;
    int         done_cnt [2], urun_cnt [2], er_cnt [2], done_cyc [2], gap [2];
    bit         armed [2];
    logic [7:0] er_byte [2];
    logic [7:0] got [2][$];
    int         dl [2][$];
    logic [7:0] pay [$], exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rgmii_tx_framer #(.MIN_FRAME(g == 0 ? 0 : 60), .IFG_BYTES(12)) dut (
            .clk(clk), .rst(rst), .s_tdata(tdata[g]), .s_tvalid(tvalid[g]), .s_tlast(tlast[g]),
            .s_tready(tready[g]), .txd_d1(d1[g]), .txd_d2(d2[g]), .txctl_d1(c1[g]), .txctl_d2(c2[g]),
            .frame_done(done[g]), .underrun(urun[g]));
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (c1[k] && c2[k]) got[k].push_back({d2[k], d1[k]});
            if (c1[k] && !c2[k]) begin er_cnt[k]++; er_byte[k] = {d2[k], d1[k]}; end
            if (urun[k]) urun_cnt[k]++;
            if (done[k]) begin
                done_cnt[k]++;
                dl[k].push_back(got[k].size());
                done_cyc[k] = cyc;
                armed[k] = 1'b1;
            end else if (armed[k]) begin
                if (c1[k] && c2[k]) begin gap[k] = cyc - done_cyc[k] - 1; armed[k] = 1'b0; end
                else if (c1[k] || c2[k] || d1[k] != 4'h0 || d2[k] != 4'h0) idle_bad++;
            end
        end
    end

    // Expected wire bytes of one good frame: preamble, SFD, payload, zero pad, FCS LSB first.
    function automatic void build(input int minf);
        logic [31:0] c;
        logic [7:0]  b;
        int          n;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        n = pay.size() < minf ? minf : pay.size();
        for (int i = 0; i < n; i++) begin
            b = i < pay.size() ? pay[i] : 8'h00;
            exp_q.push_back(b);
            c = c ^ {24'h0, b};
            for (int j = 0; j < 8; j++) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    endfunction

    task automatic rand_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    task automatic wait_ready(input int k);
        int t = 0;
        @(negedge clk);
        while (!tready[k] && t < 300) begin t++; @(negedge clk); end
        if (t >= 300) check("ready_timeout", 32'(tready[k]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int under_at, input int stop_at, input bit keep);
        for (int i = 0; i < pay.size(); i++) begin
            if (i == stop_at) break;
            tdata[k] = pay[i];
            tlast[k] = (i == pay.size() - 1);
            tvalid[k] = 1'b1;
            wait_ready(k);
            if (i + 1 == under_at) begin
                tvalid[k] = 1'b0;
                tlast[k] = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        tlast[k] = 1'b0;
        if (!keep) tvalid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int n);
        int t = 0;
        while (done_cnt[k] < n && t < 1000) begin t++; @(negedge clk); end
        check("done_count", done_cnt[k], n);
    endtask

    task automatic cmp(input int k);
        check("frame_len", got[k].size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got[k].size(); i++) check("frame_byte", {24'h0, got[k][i]}, {24'h0, exp_q[i]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, n, u0, e0, d0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin tvalid[i] = 1'b0; tlast[i] = 1'b0; tdata[i] = 8'h00; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_txd", {24'h0, d2[i], d1[i]}, 32'h0);
            check("rst_ctl", {30'h0, c1[i], c2[i]}, 32'h0);
            check("rst_ready", 32'(tready[i]), 32'h0);
            check("rst_pulses", {30'h0, done[i], urun[i]}, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp_q.delete(); build(0);
        send(0, -1, -1, 0);
        wait_done(0, 1);
        check("check_len", dl[0][0], 21);
        check("fcs_b0", {24'h0, got[0][17]}, 32'h26);
        check("fcs_b1", {24'h0, got[0][18]}, 32'h39);
        check("fcs_b2", {24'h0, got[0][19]}, 32'hF4);
        check("fcs_b3", {24'h0, got[0][20]}, 32'hCB);
        cmp(0);

        pay = '{8'hA7};
        got[0].delete();
        send(0, -1, -1, 0);
        wait_done(0, 2);
        check("nib_d1", {28'h0, got[0][8][3:0]}, 32'h7);
        check("nib_d2", {28'h0, got[0][8][7:4]}, 32'hA);

        rand_pay(14);
        exp_q.delete(); build(60);
        send(1, -1, -1, 1);
        rand_pay(25);
        build(60);
        send(1, -1, -1, 0);
        wait_done(1, 2);
        check("pad_len", dl[1][0], 72);
        check("b2b_gap", gap[1], 13);
        cmp(1);

        rand_pay(10);
        got[1].delete();
        u0 = urun_cnt[1]; e0 = er_cnt[1]; d0 = done_cnt[1];
        send(1, 5, -1, 0);
        repeat (20) @(negedge clk);
        check("urun_bytes", got[1].size(), 13);
        check("urun_last", {24'h0, got[1][12]}, {24'h0, pay[4]});
        check("urun_pulse", urun_cnt[1] - u0, 1);
        check("urun_er", er_cnt[1] - e0, 1);
        check("urun_erbyte", {24'h0, er_byte[1]}, 32'h0);
        check("urun_nofcs", done_cnt[1] - d0, 0);

        repeat (8) begin
            k = int'($urandom_range(0, 1));
            rand_pay(int'($urandom_range(1, 90)));
            exp_q.delete(); build(k == 1 ? 60 : 0);
            got[k].delete();
            n = done_cnt[k];
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            send(k, -1, -1, 0);
            wait_done(k, n + 1);
            cmp(k);
        end

        rand_pay(40);
        got[1].delete();
        send(1, -1, 20, 1);
        rst = 1'b1;
        tvalid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_txd", {24'h0, d2[1], d1[1]}, 32'h0);
        check("mid_rst_ctl", {30'h0, c1[1], c2[1]}, 32'h0);
        check("mid_rst_ready", 32'(tready[1]), 32'h0);
        check("mid_rst_pulses", {30'h0, done[1], urun[1]}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        rand_pay(30);
        exp_q.delete(); build(60);
        got[1].delete();
        n = done_cnt[1];
        send(1, -1, -1, 0);
        wait_done(1, n + 1);
        cmp(1);

        check("idle_clean", idle_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
